xillybus_mem_port: RTL and testbench

- Parametrised successor to the fixed 8-bit, 32-entry seekable memory device on the Xillybus user side (the mem_8 channel).
- Terminates one seekable Xillybus read/write stream pair into an on-chip synchronous RAM.
- Data width, depth and end-of-memory mode are set by parameters.
- Holds LeNet weight and feature buffers that the host loads by seek-and-write and reads back by seek-and-read.

---
 rtl/xillybus_mem_port_if.sv | 46 ++++
 rtl/xillybus_mem_port.sv | 115 +++++++++++
 tb/tb_xillybus_mem_port.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xillybus_mem_port_if.sv
// Host-side Xillybus signal bundle for one seekable read/write stream pair
// terminated by xillybus_mem_port.
interface xillybus_mem_port_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
) ();
   logic              user_r_mem_rden;
   logic [DATA_W-1:0] user_r_mem_data;
   logic              user_r_mem_empty;
   logic              user_r_mem_eof;
   logic              user_r_mem_open;
   logic              user_w_mem_wren;
   logic [DATA_W-1:0] user_w_mem_data;
   logic              user_w_mem_full;
   logic              user_w_mem_open;
   logic [ADDR_W-1:0] user_mem_addr;
   logic              user_mem_addr_update;

   modport master (
      output user_r_mem_rden,
      input  user_r_mem_data,
      input  user_r_mem_empty,
      input  user_r_mem_eof,
      output user_r_mem_open,
      output user_w_mem_wren,
      output user_w_mem_data,
      input  user_w_mem_full,
      output user_w_mem_open,
      output user_mem_addr,
      output user_mem_addr_update
   );

   modport slave (
      input  user_r_mem_rden,
      output user_r_mem_data,
      output user_r_mem_empty,
      output user_r_mem_eof,
      input  user_r_mem_open,
      input  user_w_mem_wren,
      input  user_w_mem_data,
      output user_w_mem_full,
      input  user_w_mem_open,
      input  user_mem_addr,
      input  user_mem_addr_update
   );
endinterface

// File: rtl/xillybus_mem_port.sv
// Seekable Xillybus read/write stream pair backed by an on-chip synchronous RAM.
// Define XILLY_MEM_APP_PORT_EN to expose a second RAM port (app_*) to the accelerator.
module xillybus_mem_port #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5,
   parameter int WRAP   = 1
) (
   input  logic               bus_clk,
   input  logic               bus_rst_n,
   xillybus_mem_port_if.slave mem_bus
`ifdef XILLY_MEM_APP_PORT_EN
   ,
   input  logic [ADDR_W-1:0]  app_addr,
   input  logic               app_rden,
   output logic [DATA_W-1:0]  app_rd_data,
   input  logic               app_wren,
   input  logic [DATA_W-1:0]  app_wr_data
`endif
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] ptr_reg;
   logic [ADDR_W-1:0] ptr_next;
   logic              atend_reg;
   logic              atend_next;
   logic [DATA_W-1:0] rd_data_reg;
   logic              r_open_reg;
   logic              w_open_reg;

   logic              rd_acc;
   logic              wr_acc;
   logic              open_rise;

   // atend_reg is never set when wrapping, so every access is accepted then.
   assign rd_acc    = mem_bus.user_r_mem_rden & ~atend_reg;
   assign wr_acc    = mem_bus.user_w_mem_wren & ~atend_reg;
   assign open_rise = (mem_bus.user_r_mem_open & ~r_open_reg) |
                      (mem_bus.user_w_mem_open & ~w_open_reg);

   always_comb begin
      ptr_next   = ptr_reg;
      atend_next = atend_reg;
      if (mem_bus.user_mem_addr_update) begin
         ptr_next   = mem_bus.user_mem_addr;
         atend_next = 1'b0;
      end else begin
         if (open_rise) begin
            atend_next = 1'b0;
         end
         // A simultaneous read and write share one slot: a single increment.
         if (rd_acc | wr_acc) begin
            if (WRAP != 0 || ptr_reg != LAST) begin
               ptr_next = ptr_reg + ADDR_W'(1);
            end else begin
               atend_next = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge bus_clk or negedge bus_rst_n) begin
      if (!bus_rst_n) begin
         ptr_reg     <= '0;
         atend_reg   <= 1'b0;
         rd_data_reg <= '0;
         r_open_reg  <= 1'b0;
         w_open_reg  <= 1'b0;
      end else begin
         ptr_reg    <= ptr_next;
         atend_reg  <= atend_next;
         r_open_reg <= mem_bus.user_r_mem_open;
         w_open_reg <= mem_bus.user_w_mem_open;
         if (rd_acc) begin
            rd_data_reg <= mem[ptr_reg];
         end
      end
   end

   // RAM contents survive reset; writes are held off while reset is asserted.
   // The host write is issued last so it wins a same-address collision.
   always_ff @(posedge bus_clk) begin
`ifdef XILLY_MEM_APP_PORT_EN
      if (app_wren && bus_rst_n) begin
         mem[app_addr] <= app_wr_data;
      end
`endif
      if (wr_acc && bus_rst_n) begin
         mem[ptr_reg] <= mem_bus.user_w_mem_data;
      end
   end

`ifdef XILLY_MEM_APP_PORT_EN
   logic [DATA_W-1:0] app_rd_data_reg;

   always_ff @(posedge bus_clk or negedge bus_rst_n) begin
      if (!bus_rst_n) begin
         app_rd_data_reg <= '0;
      end else if (app_rden) begin
         app_rd_data_reg <= mem[app_addr];
      end
   end

   assign app_rd_data = app_rd_data_reg;
`endif

   assign mem_bus.user_r_mem_data  = rd_data_reg;
   assign mem_bus.user_r_mem_empty = atend_reg;
   assign mem_bus.user_r_mem_eof   = atend_reg;
   assign mem_bus.user_w_mem_full  = atend_reg;

endmodule

// File: tb/tb_xillybus_mem_port.sv
// Bench for xillybus_mem_port: a wrapping and a stop-at-end instance share one
// stimulus stream and are checked against a word-level memory model.
module tb_xillybus_mem_port;
   localparam int DW    = 8;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic bus_clk   = 1'b0;
   logic bus_rst_n = 1'b1;
   always #5 bus_clk = ~bus_clk;

   logic          rden, wren, upd, ropen, wopen;
   logic [DW-1:0] wdata;
   logic [AW-1:0] addr;

   int vectors     = 0;
   int miscompares = 0;

   xillybus_mem_port_if #(.DATA_W(DW), .ADDR_W(AW)) bus_w ();
   xillybus_mem_port_if #(.DATA_W(DW), .ADDR_W(AW)) bus_s ();

   assign bus_w.user_r_mem_rden      = rden;
   assign bus_w.user_r_mem_open      = ropen;
   assign bus_w.user_w_mem_wren      = wren;
   assign bus_w.user_w_mem_data      = wdata;
   assign bus_w.user_w_mem_open      = wopen;
   assign bus_w.user_mem_addr        = addr;
   assign bus_w.user_mem_addr_update = upd;
   assign bus_s.user_r_mem_rden      = rden;
   assign bus_s.user_r_mem_open      = ropen;
   assign bus_s.user_w_mem_wren      = wren;
   assign bus_s.user_w_mem_data      = wdata;
   assign bus_s.user_w_mem_open      = wopen;
   assign bus_s.user_mem_addr        = addr;
   assign bus_s.user_mem_addr_update = upd;

`ifdef XILLY_MEM_APP_PORT_EN
   logic [AW-1:0] app_addr;
   logic          app_rden, app_wren;
   logic [DW-1:0] app_wr_data;
   logic [DW-1:0] app_rd_w, app_rd_s;
`endif

   xillybus_mem_port #(.DATA_W(DW), .ADDR_W(AW), .WRAP(1)) dut_w (
      .bus_clk     (bus_clk),
      .bus_rst_n   (bus_rst_n),
      .mem_bus     (bus_w.slave)
`ifdef XILLY_MEM_APP_PORT_EN
      ,
      .app_addr    (app_addr),
      .app_rden    (app_rden),
      .app_rd_data (app_rd_w),
      .app_wren    (app_wren),
      .app_wr_data (app_wr_data)
`endif
   );

   xillybus_mem_port #(.DATA_W(DW), .ADDR_W(AW), .WRAP(0)) dut_s (
      .bus_clk     (bus_clk),
      .bus_rst_n   (bus_rst_n),
      .mem_bus     (bus_s.slave)
`ifdef XILLY_MEM_APP_PORT_EN
      ,
      .app_addr    (app_addr),
      .app_rden    (app_rden),
      .app_rd_data (app_rd_s),
      .app_wren    (app_wren),
      .app_wr_data (app_wr_data)
`endif
   );

   // Reference model; index 0 is the wrapping instance, 1 the stop-at-end one.
   logic [DW-1:0] m_mem   [2][DEPTH];
   bit            m_known [2][DEPTH];
   int            m_ptr   [2];
   bit            m_end   [2];
   logic [DW-1:0] m_rdata [2];
   bit            m_rknown[2];
   logic [DW-1:0] m_app   [2];
   bit            m_aknown[2];
   bit            m_prev_r, m_prev_w;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_ptr[d]    = 0;
         m_end[d]    = 1'b0;
         m_rdata[d]  = '0;
         m_rknown[d] = 1'b1;
         m_app[d]    = '0;
         m_aknown[d] = 1'b1;
      end
      m_prev_r = 1'b0;
      m_prev_w = 1'b0;
   endtask

   task automatic model_clock();
      bit rise, rd_ok, wr_ok;
      rise     = (ropen && !m_prev_r) || (wopen && !m_prev_w);
      m_prev_r = ropen;
      m_prev_w = wopen;
      for (int d = 0; d < 2; d++) begin
         rd_ok = rden && !m_end[d];
         wr_ok = wren && !m_end[d];
`ifdef XILLY_MEM_APP_PORT_EN
         if (app_rden) begin
            m_app[d]    = m_mem[d][app_addr];
            m_aknown[d] = m_known[d][app_addr];
         end
`endif
         if (rd_ok) begin
            m_rdata[d]  = m_mem[d][m_ptr[d]];
            m_rknown[d] = m_known[d][m_ptr[d]];
         end
`ifdef XILLY_MEM_APP_PORT_EN
         if (app_wren) begin
            m_mem[d][app_addr]   = app_wr_data;
            m_known[d][app_addr] = 1'b1;
         end
`endif
         if (wr_ok) begin
            m_mem[d][m_ptr[d]]   = wdata;
            m_known[d][m_ptr[d]] = 1'b1;
         end
         if (upd) begin
            m_ptr[d] = int'(addr);
            m_end[d] = 1'b0;
         end else begin
            if (rise) m_end[d] = 1'b0;
            if (rd_ok || wr_ok) begin
               if (d == 0) m_ptr[d] = (m_ptr[d] + 1) % DEPTH;
               else if (m_ptr[d] == DEPTH - 1) m_end[d] = 1'b1;
               else m_ptr[d] = m_ptr[d] + 1;
            end
         end
      end
   endtask

   task automatic check_dut(input int d, input string nm, input logic [DW-1:0] data,
                            input logic empty, input logic eof, input logic full);
      if (m_rknown[d]) check({nm, ".data"}, 32'(data), 32'(m_rdata[d]));
      check({nm, ".empty"}, 32'(empty), 32'(m_end[d]));
      check({nm, ".eof"},   32'(eof),   32'(m_end[d]));
      check({nm, ".full"},  32'(full),  32'(m_end[d]));
   endtask

   task automatic check_outputs();
      check_dut(0, "wrap", bus_w.user_r_mem_data, bus_w.user_r_mem_empty,
                bus_w.user_r_mem_eof, bus_w.user_w_mem_full);
      check_dut(1, "stop", bus_s.user_r_mem_data, bus_s.user_r_mem_empty,
                bus_s.user_r_mem_eof, bus_s.user_w_mem_full);
`ifdef XILLY_MEM_APP_PORT_EN
      if (m_aknown[0]) check("wrap.app_rd_data", 32'(app_rd_w), 32'(m_app[0]));
      if (m_aknown[1]) check("stop.app_rd_data", 32'(app_rd_s), 32'(m_app[1]));
`endif
   endtask

   // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
   task automatic step(input bit r, input bit w, input logic [DW-1:0] wd,
                       input bit u, input logic [AW-1:0] a);
      rden  = r;
      wren  = w;
      wdata = wd;
      upd   = u;
      addr  = a;
      @(posedge bus_clk);
      model_clock();
      #1;
      check_outputs();
      rden = 1'b0;
      wren = 1'b0;
      upd  = 1'b0;
`ifdef XILLY_MEM_APP_PORT_EN
      app_rden = 1'b0;
      app_wren = 1'b0;
`endif
   endtask

   task automatic seek(input logic [AW-1:0] a);
      step(1'b0, 1'b0, '0, 1'b1, a);
   endtask

   initial begin
      rden = 0; wren = 0; upd = 0; ropen = 1; wopen = 1; wdata = '0; addr = '0;
`ifdef XILLY_MEM_APP_PORT_EN
      app_addr = '0; app_rden = 0; app_wren = 0; app_wr_data = '0;
`endif
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < DEPTH; i++) begin
            m_mem[d][i]   = '0;
            m_known[d][i] = 1'b0;
         end

      // Power-on reset, checked before any clock edge.
      #2 bus_rst_n = 1'b0;
      #1 model_reset();
      check_outputs();
      @(posedge bus_clk);
      @(posedge bus_clk);
      #1 bus_rst_n = 1'b1;

      // Seek-write then seek-read of three words.
      seek(5'd3);
      step(0, 1, 8'hA1, 0, '0);
      step(0, 1, 8'hA2, 0, '0);
      step(0, 1, 8'hA3, 0, '0);
      seek(5'd3);
      for (int i = 0; i < 3; i++) step(1, 0, '0, 0, '0);
      step(1, 0, '0, 0, '0);

      // End of memory: wrap versus stop.
      seek(5'd31);
      step(0, 1, 8'h11, 0, '0);
      step(0, 1, 8'h22, 0, '0);
      seek(5'd31);
      step(1, 0, '0, 0, '0);
      step(1, 0, '0, 0, '0);
      seek(5'd30);
      step(0, 1, 8'h05, 0, '0);
      step(0, 1, 8'h06, 0, '0);
      step(0, 1, 8'h07, 0, '0);
      step(1, 0, '0, 0, '0);
      seek(5'd0);
      step(0, 0, '0, 0, '0);
      seek(5'd30);
      step(1, 0, '0, 0, '0);
      step(1, 0, '0, 0, '0);
      step(1, 0, '0, 0, '0);

      // Read-first on a simultaneous read and write.
      seek(5'd4);
      step(0, 1, 8'h33, 0, '0);
      seek(5'd4);
      step(1, 1, 8'h44, 0, '0);
      seek(5'd4);
      step(1, 0, '0, 0, '0);
      step(1, 0, '0, 0, '0);

      // Seek in the same cycle as a write uses the old pointer.
      seek(5'd2);
      step(0, 1, 8'h77, 1, 5'd9);
      step(0, 1, 8'h99, 0, '0);
      seek(5'd2);
      step(1, 0, '0, 0, '0);
      seek(5'd9);
      step(1, 0, '0, 0, '0);

      // Open edges: falling keeps the end flag, rising clears it.
      seek(5'd31);
      step(0, 1, 8'hE1, 0, '0);
      wopen = 1'b0;
      step(0, 0, '0, 0, '0);
      step(0, 1, 8'hE2, 0, '0);
      wopen = 1'b1;
      step(0, 0, '0, 0, '0);
      step(1, 0, '0, 0, '0);
      ropen = 1'b0;
      step(0, 0, '0, 0, '0);
      ropen = 1'b1;
      step(0, 0, '0, 0, '0);

`ifdef XILLY_MEM_APP_PORT_EN
      seek(5'd7);
      step(0, 1, 8'hBE, 0, '0);
      app_addr = 5'd7; app_rden = 1'b1;
      step(0, 0, '0, 0, '0);
      seek(5'd7);
      app_addr = 5'd7; app_wren = 1'b1; app_wr_data = 8'hC3;
      step(0, 1, 8'h5A, 0, '0);
      app_addr = 5'd7; app_rden = 1'b1;
      step(0, 0, '0, 0, '0);
      seek(5'd7);
      step(1, 0, '0, 0, '0);
`endif

      // Fill the whole RAM, then random traffic biased toward the end.
      seek(5'd0);
      for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(i * 7 + 3), 0, '0);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) ropen = ~ropen;
         if ($urandom_range(0, 15) == 0) wopen = ~wopen;
`ifdef XILLY_MEM_APP_PORT_EN
         app_addr    = 5'($urandom);
         app_rden    = 1'($urandom);
         app_wren    = ($urandom_range(0, 3) == 0);
         app_wr_data = 8'($urandom);
`endif
         step(1'($urandom), 1'($urandom), 8'($urandom),
              $urandom_range(0, 7) == 0,
              $urandom_range(0, 1) ? 5'(28 + $urandom_range(0, 3)) : 5'($urandom));
      end
      ropen = 1'b1;
      wopen = 1'b1;

      // Reset mid-stream with the stop instance at its end.
      seek(5'd30);
      step(1, 1, 8'hF0, 0, '0);
      step(1, 1, 8'hF1, 0, '0);
      #2 bus_rst_n = 1'b0;
      #1 model_reset();
      check_outputs();
      @(posedge bus_clk);
      @(posedge bus_clk);
      #1 bus_rst_n = 1'b1;
      step(1, 0, '0, 0, '0);
      step(1, 0, '0, 0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
